// File: rtl/ext_pwrgate_pkg.sv
// Shared types and helpers for the external power-gate sequencer.
// The sequencer FSM states and the cycle-counter sizing live here.
package ext_pwrgate_pkg;

  typedef enum logic [3:0] {
    IDLE,
    OFF_ISO,
    OFF_RST,
    OFF_SW,
    ON_SW,
    ON_SETTLE,
    ON_RST,
    ON_ISO,
    DONE
  } pg_state_e;

  // A cycle count of 0 behaves as a single cycle.
  function automatic int eff_cycles(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int cnt_width(input int iso, input int settle, input int timeout);
    int m;
    m = eff_cycles(iso);
    if (eff_cycles(settle) > m) m = eff_cycles(settle);
    if (eff_cycles(timeout) > m) m = eff_cycles(timeout);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ext_pwrgate_sched_if.sv
// Pin bundle between the power-manager side and the domain switch/iso pins.
// The master drives requests and models the switch-cell ack; the slave is the sequencer.
interface ext_pwrgate_sched_if #(
  parameter int N_DOMAINS = 4
);

  logic [N_DOMAINS-1:0] target_on_i;
  logic [N_DOMAINS-1:0] err_clear_i;
  logic [N_DOMAINS-1:0] switch_ack_i;
  logic [N_DOMAINS-1:0] switch_o;
  logic [N_DOMAINS-1:0] iso_o;
  logic [N_DOMAINS-1:0] domain_rst_no;
  logic [N_DOMAINS-1:0] status_on_o;
  logic [N_DOMAINS-1:0] err_o;
  logic                 busy_o;

  modport master (
    output target_on_i, err_clear_i, switch_ack_i,
    input  switch_o, iso_o, domain_rst_no, status_on_o, err_o, busy_o
  );

  modport slave (
    input  target_on_i, err_clear_i, switch_ack_i,
    output switch_o, iso_o, domain_rst_no, status_on_o, err_o, busy_o
  );

endinterface

// File: rtl/ext_pwrgate_sched_rr_pick.sv
// Round-robin first-set-bit finder: scans req_i starting at ptr_i with wrap-around.
module pg_rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise a latch is inferred for the hold case.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < N; i++) begin
      if (!valid_o && req_i[(int'(ptr_i) + i) % N]) begin
        valid_o = 1'b1;
        idx_o   = IW'((int'(ptr_i) + i) % N);
      end
    end
  end

endmodule

// File: rtl/ext_pwrgate_sched.sv
// Power-gate sequencer: serves one domain at a time, round-robin, driving
// switch / isolation / domain reset in a safe order and waiting on the switch ack.
module ext_pwrgate_sched
  import ext_pwrgate_pkg::*;
#(
  parameter int N_DOMAINS      = 4,
  parameter int ISO_CYCLES     = 2,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ext_pwrgate_sched_if.slave  pg
);

  localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
  localparam int CNT_W = cnt_width(ISO_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0] ISO_LAST    = CNT_W'(eff_cycles(ISO_CYCLES) - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(eff_cycles(SETTLE_CYCLES) - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(eff_cycles(TIMEOUT_CYCLES) - 1);

  pg_state_e            state_q, state_d;
  logic [IDX_W-1:0]     cur_q, cur_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_DOMAINS-1:0] switch_q, switch_d;
  logic [N_DOMAINS-1:0] iso_q, iso_d;
  logic [N_DOMAINS-1:0] rst_n_q, rst_n_d;
  logic [N_DOMAINS-1:0] status_q, status_d;
  logic [N_DOMAINS-1:0] err_q, err_d;
  logic [N_DOMAINS-1:0] ack_meta_q, ack_s_q;

  logic [N_DOMAINS-1:0] cand;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic                 ack_cur;

  // Two-flop synchroniser per ack bit; the raw ack is never used elsewhere.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_meta_q <= '0;
      ack_s_q    <= '0;
    end else begin
      ack_meta_q <= pg.switch_ack_i;
      ack_s_q    <= ack_meta_q;
    end
  end

  assign cand    = (pg.target_on_i ^ status_q) & ~err_q;
  assign ack_cur = ack_s_q[cur_q];

  pg_rr_pick #(.N(N_DOMAINS)) u_pick (
    .req_i   (cand),
    .ptr_i   (rr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    switch_d = switch_q;
    iso_d    = iso_q;
    rst_n_d  = rst_n_q;
    status_d = status_q;
    // A clear pulse coinciding with a new timeout loses: the set below overrides.
    err_d    = err_q & ~pg.err_clear_i;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          cur_d = pick_idx;
          cnt_d = '0;
          if (pg.target_on_i[pick_idx]) begin
            state_d            = ON_SW;
            switch_d[pick_idx] = 1'b1;
          end else begin
            state_d            = OFF_ISO;
            iso_d[pick_idx]    = 1'b1;
            status_d[pick_idx] = 1'b0;
          end
        end
      end
      OFF_ISO: begin
        if (cnt_q == ISO_LAST) begin
          state_d        = OFF_RST;
          rst_n_d[cur_q] = 1'b0;
          cnt_d          = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OFF_RST: begin
        state_d         = OFF_SW;
        switch_d[cur_q] = 1'b0;
        cnt_d           = '0;
      end
      OFF_SW: begin
        if (!ack_cur) begin
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          state_d      = DONE;
          err_d[cur_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ON_SW: begin
        if (ack_cur) begin
          state_d = ON_SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          // Give up: back to the fully-off configuration and flag the domain.
          state_d         = DONE;
          err_d[cur_q]    = 1'b1;
          switch_d[cur_q] = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ON_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d        = ON_RST;
          rst_n_d[cur_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ON_RST: begin
        state_d         = ON_ISO;
        iso_d[cur_q]    = 1'b0;
        status_d[cur_q] = 1'b1;
      end
      ON_ISO: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        rr_d    = (int'(cur_q) == N_DOMAINS - 1) ? '0 : cur_q + IDX_W'(1);
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
      switch_q <= '0;
      iso_q    <= '1;
      rst_n_q  <= '0;
      status_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      switch_q <= switch_d;
      iso_q    <= iso_d;
      rst_n_q  <= rst_n_d;
      status_q <= status_d;
      err_q    <= err_d;
    end
  end

  assign pg.switch_o      = switch_q;
  assign pg.iso_o         = iso_q;
  assign pg.domain_rst_no = rst_n_q;
  assign pg.status_on_o   = status_q;
  assign pg.err_o         = err_q;
  assign pg.busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_ext_pwrgate_sched.sv
// Directed bench for ext_pwrgate_sched with two domains and a switch model that
// echoes switch_o after 15 cycles.
module tb_ext_pwrgate_sched;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ack_en = 1'b1;
  logic [N-1:0] ack_pipe [15];

  int n_cmp  = 0;
  int n_fail = 0;
  int viol   = 0;

  ext_pwrgate_sched_if #(.N_DOMAINS(N)) pg ();

  ext_pwrgate_sched #(
    .N_DOMAINS      (N),
    .ISO_CYCLES     (2),
    .SETTLE_CYCLES  (4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .pg    (pg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ack_pipe[0] <= ack_en ? pg.switch_o : '0;
    for (int i = 1; i < 15; i++) ack_pipe[i] <= ack_pipe[i-1];
  end
  assign pg.switch_ack_i = ack_en ? ack_pipe[14] : '0;

  // A de-isolated domain must always be switched on and out of reset.
  always @(negedge clk) begin
    if (!rst && |(~pg.iso_o & ~(pg.switch_o & pg.domain_rst_no))) viol++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (pg.busy_o && k < budget) begin
      step(1);
      k++;
    end
    check(tag, 32'(pg.busy_o), 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(20);
  endtask

  initial begin
    for (int i = 0; i < 15; i++) ack_pipe[i] = '0;
    pg.target_on_i = '0;
    pg.err_clear_i = '0;
    step(3);
    check("rst_switch", 32'(pg.switch_o), 0);
    check("rst_iso", 32'(pg.iso_o), 3);
    check("rst_drst", 32'(pg.domain_rst_no), 0);
    check("rst_status", 32'(pg.status_on_o), 0);
    check("rst_err", 32'(pg.err_o), 0);
    check("rst_busy", 32'(pg.busy_o), 0);
    rst = 1'b0;
    step(2);

    // Power-on d0
    pg.target_on_i = 2'b01;
    step(1);
    check("on_switch_t1", 32'(pg.switch_o), 1);
    check("on_busy_t1", 32'(pg.busy_o), 1);
    check("on_iso_t1", 32'(pg.iso_o), 3);
    step(21);
    check("on_drst_t22", 32'(pg.domain_rst_no), 0);
    step(1);
    check("on_drst_t23", 32'(pg.domain_rst_no), 1);
    check("on_iso_t23", 32'(pg.iso_o), 3);
    step(1);
    check("on_iso_t24", 32'(pg.iso_o), 2);
    check("on_status_t24", 32'(pg.status_on_o), 1);
    step(1);
    check("on_busy_t25", 32'(pg.busy_o), 1);
    step(1);
    check("on_busy_t26", 32'(pg.busy_o), 0);

    // Power-off d0
    pg.target_on_i = 2'b00;
    step(1);
    check("off_iso_t1", 32'(pg.iso_o), 3);
    check("off_status_t1", 32'(pg.status_on_o), 0);
    check("off_drst_t1", 32'(pg.domain_rst_no), 1);
    step(2);
    check("off_drst_t3", 32'(pg.domain_rst_no), 0);
    check("off_switch_t3", 32'(pg.switch_o), 1);
    step(1);
    check("off_switch_t4", 32'(pg.switch_o), 0);
    step(18);
    check("off_busy_t22", 32'(pg.busy_o), 1);
    step(1);
    check("off_busy_t23", 32'(pg.busy_o), 0);

    // Simultaneous requests, rr=0 then rr=1
    pulse_reset();
    pg.target_on_i = 2'b11;
    step(1);
    check("sim_switch_t1", 32'(pg.switch_o), 1);
    step(25);
    check("sim_switch_t26", 32'(pg.switch_o), 1);
    check("sim_status_t26", 32'(pg.status_on_o), 1);
    step(1);
    check("sim_switch_t27", 32'(pg.switch_o), 3);
    wait_idle("sim_idle1", 60);
    check("sim_status_both", 32'(pg.status_on_o), 3);
    pg.target_on_i = 2'b10;
    step(1);
    wait_idle("sim_idle2", 40);
    check("sim_switch_d1only", 32'(pg.switch_o), 2);
    pg.target_on_i = 2'b01;
    step(1);
    check("rev_iso_t1", 32'(pg.iso_o), 3);
    check("rev_status_t1", 32'(pg.status_on_o), 0);
    check("rev_switch_t1", 32'(pg.switch_o), 2);
    step(22);
    check("rev_busy_t23", 32'(pg.busy_o), 0);
    check("rev_switch_t23", 32'(pg.switch_o), 0);
    step(1);
    check("rev_switch_t24", 32'(pg.switch_o), 1);
    wait_idle("rev_idle", 40);
    check("rev_status_end", 32'(pg.status_on_o), 1);

    // Ack timeout, set-wins clear, then retry
    pg.target_on_i = 2'b00;
    ack_en = 1'b0;
    pulse_reset();
    pg.target_on_i = 2'b01;
    step(1);
    check("to_switch_t1", 32'(pg.switch_o), 1);
    step(63);
    check("to_err_t64", 32'(pg.err_o), 0);
    check("to_switch_t64", 32'(pg.switch_o), 1);
    pg.err_clear_i = 2'b01;
    step(1);
    pg.err_clear_i = 2'b00;
    check("to_err_t65", 32'(pg.err_o), 1);
    check("to_switch_t65", 32'(pg.switch_o), 0);
    check("to_iso_t65", 32'(pg.iso_o), 3);
    check("to_busy_t65", 32'(pg.busy_o), 1);
    step(11);
    check("to_skip_switch", 32'(pg.switch_o), 0);
    check("to_skip_busy", 32'(pg.busy_o), 0);
    ack_en = 1'b1;
    pg.err_clear_i = 2'b01;
    step(1);
    pg.err_clear_i = 2'b00;
    check("to_err_cleared", 32'(pg.err_o), 0);
    step(1);
    check("to_retry_switch", 32'(pg.switch_o), 1);
    check("to_retry_busy", 32'(pg.busy_o), 1);
    wait_idle("to_retry_idle", 60);
    check("to_retry_status", 32'(pg.status_on_o), 1);

    // Reset in the middle of ON_SETTLE
    pg.target_on_i = 2'b00;
    pulse_reset();
    pg.target_on_i = 2'b01;
    step(20);
    check("mr_busy_pre", 32'(pg.busy_o), 1);
    check("mr_switch_pre", 32'(pg.switch_o), 1);
    rst = 1'b1;
    pg.target_on_i = 2'b00;
    step(1);
    check("mr_switch", 32'(pg.switch_o), 0);
    check("mr_iso", 32'(pg.iso_o), 3);
    check("mr_drst", 32'(pg.domain_rst_no), 0);
    check("mr_busy", 32'(pg.busy_o), 0);
    rst = 1'b0;
    step(20);

    // Target toggled back mid-sequence
    pg.target_on_i = 2'b01;
    step(5);
    pg.target_on_i = 2'b00;
    step(19);
    check("tg_status_t24", 32'(pg.status_on_o), 1);
    check("tg_iso_t24", 32'(pg.iso_o), 2);
    step(2);
    check("tg_busy_t26", 32'(pg.busy_o), 0);
    check("tg_status_t26", 32'(pg.status_on_o), 1);
    step(1);
    check("tg_iso_t27", 32'(pg.iso_o), 3);
    check("tg_status_t27", 32'(pg.status_on_o), 0);
    check("tg_busy_t27", 32'(pg.busy_o), 1);
    wait_idle("tg_idle", 40);
    check("tg_switch_end", 32'(pg.switch_o), 0);

    check("no_iso_overlap", 32'(viol), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ext_pwrgate_sched.md
Name: ext_pwrgate_sched

Overview:
- Power-gate sequencer and scheduler for the external subsystem power domains (EXTERNAL_DOMAINS of them).
- Each domain has a level target from a control register. The block drives that domain's switch, isolation and domain reset in a safe order, and waits for the switch-cell ack.
- Only one domain switches at a time, which limits inrush current. Pending domains are served round-robin.
- Sits between the power-manager register file and the external subsystem switch/iso pins at top level.

Parameters:
- N_DOMAINS, 4, number of gated domains (set from core_v_mini_mcu_pkg::EXTERNAL_DOMAINS).
- ISO_CYCLES, 2, cycles isolation is held before switch-off starts.
- SETTLE_CYCLES, 4, cycles after switch-on ack before the domain reset is released.
- TIMEOUT_CYCLES, 64, maximum cycles to wait for the synchronised ack.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- target_on_i  in  N_DOMAINS  requested state per domain, 1 = powered
- err_clear_i  in  N_DOMAINS  one-cycle pulse that clears that domain's sticky error
- switch_o  out  N_DOMAINS  switch-cell enable, 1 = powered
- switch_ack_i  in  N_DOMAINS  switch-cell ack, asynchronous
- iso_o  out  N_DOMAINS  1 = domain outputs isolated
- domain_rst_no  out  N_DOMAINS  domain reset, active low
- status_on_o  out  N_DOMAINS  1 = domain fully on and de-isolated
- err_o  out  N_DOMAINS  sticky ack-timeout flag
- busy_o  out  1  a sequence is in progress

Behaviour:
- Reset values: switch_o=0, iso_o=all 1, domain_rst_no=0, status_on_o=0, err_o=0, busy_o=0, FSM=IDLE, rr pointer=0, counters=0, sync flops=0.
- Ack input: switch_ack_i passes through a 2-flop synchroniser (ack_s). All ack tests use ack_s.
- Candidate: domain d is a candidate when target_on_i[d] != status_on_o[d] and err_o[d] == 0.
- Arbitration in IDLE: pick the first candidate at or after the rr pointer, with wrap-around. Latch it as cur and latch its direction. The rr pointer moves to cur+1 (mod N) when the sequence finishes.
- busy_o is 1 in every state except IDLE.
- OFF sequence (grant in cycle t):
  - OFF_ISO: iso_o[cur]=1 from t+1; status_on_o[cur]=0 from t+1; count ISO_CYCLES.
  - OFF_RST: domain_rst_no[cur]=0 for one cycle.
  - OFF_SW: switch_o[cur]=0; wait for ack_s[cur]==0.
  - DONE: return to IDLE.
- ON sequence:
  - ON_SW: switch_o[cur]=1 from t+1; iso stays 1 and reset stays 0; wait for ack_s[cur]==1.
  - ON_SETTLE: count SETTLE_CYCLES.
  - ON_RST: domain_rst_no[cur]=1; one cycle.
  - ON_ISO: iso_o[cur]=0 and status_on_o[cur]=1 on the same cycle edge.
  - DONE: return to IDLE.
- DONE lasts one cycle, so the next grant happens at the earliest two cycles after the sequence completes.
- Timeout:
  - The counter resets on entry to OFF_SW/ON_SW. Reaching TIMEOUT_CYCLES-1 without the ack sets err_o[cur]=1 and goes to DONE.
  - On an ON timeout, switch_o[cur] returns to 0, iso stays 1, reset stays 0, status stays 0.
  - On an OFF timeout, outputs stay in the off configuration.
- Errored domains are skipped until err_clear_i[d].
  - err_clear_i on the same cycle the error is set: set wins.
- target_on_i changes mid-sequence are ignored. The domain is re-evaluated as a candidate after DONE. A toggle-back before completion therefore causes a second, opposite sequence.
- Ack already at the expected value on entry (stale ack) is accepted. The minimum wait is therefore 1 cycle.
- rst_i mid-sequence: all outputs return to their reset values on the next edge, i.e. every domain is off, isolated and in reset.
- Cycle counters are width $clog2(max(ISO_CYCLES,SETTLE_CYCLES,TIMEOUT_CYCLES)+1). A parameter value of 0 is treated as 1.

Decomposition:
- Shared package ext_pwrgate_pkg holds:
  - pg_state_e: IDLE, OFF_ISO, OFF_RST, OFF_SW, ON_SW, ON_SETTLE, ON_RST, ON_ISO, DONE.
  - the counter-width function.
- One sub-module, pg_rr_pick: combinational round-robin first-set-bit finder over N_DOMAINS starting at the pointer. It returns valid and index.
- Synchroniser: reuse the existing sync cell, one per bit.

Test Plan:
Bench setup: N_DOMAINS=2, ISO_CYCLES=2, SETTLE_CYCLES=4, TIMEOUT_CYCLES=64, switch model echoing switch_o after a 15-cycle delay.
- Power-on d0: target_on_i=01 at cycle 0 -> switch_o[0]=1 at cycle 1; domain_rst_no[0]=1 and then iso_o[0]=0 with status_on_o[0]=1 after ack_s (cycle ~18) plus 4 settle cycles; busy_o low afterwards.
- Power-off d0 from on: target 00 -> iso_o[0]=1 and status 0 at cycle 1; reset asserted after 2 cycles; switch_o[0]=0; returns to IDLE after ack_s drops; sequence never overlaps switch with iso=0.
- Simultaneous requests: target 11 from all-off with rr=0 -> d0 fully sequenced first; d1's switch_o rises only after d0's DONE; then the reverse order with rr=1.
- Timeout: ack model disabled, target 01 -> err_o[0]=1 after 64 cycles in ON_SW; switch_o[0] back to 0; d0 not re-granted; err_clear_i[0] pulse -> sequence retried.
- Reset mid ON_SETTLE: rst_i=1 for one cycle -> next edge switch_o=0, iso_o=11, domain_rst_no=00, busy_o=0.
- Toggle mid-sequence: target 01 then 00 at cycle 5 -> ON completes (status 1), then an OFF sequence starts two cycles after DONE.
